lsu_mem_adapter: RTL and testbench
==================================

Name: lsu_mem_adapter

Overview:
Load/store adapter that sits directly upstream of the data memory, between the execute stage and dmem. It accepts one load/store request at a time and generates the word-aligned address, the 32-bit bit-granular write mask and the lane-shifted write data that dmem consumes. It extracts and sign/zero-extends load data from dmem's combinational read port. Accesses that cross a word boundary are split into two sequential dmem accesses.

Parameters:
SUPPORT_MISALIGNED, 1, 1: word-crossing accesses are split into two accesses; 0: they return resp_err without any memory access.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  adapter can accept a request (IDLE only)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse (loads and stores)
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  illegal funct3, or crossing access with SUPPORT_MISALIGNED=0
mem_we  out  1  to dmem we
mem_a  out  32  to dmem a, always word-aligned
mem_wd  out  32  to dmem wd
mem_wmask  out  32  to dmem write_mask, 0xFF per enabled byte lane
mem_rd  in  32  from dmem rd, combinational

Behaviour:
- States: IDLE, LO, HI, DONE. Reset (sync): state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, all captured registers 0.
- IDLE: req_ready=1. On req_valid, capture we/funct3/addr/wdata, then go to LO. Requests in other states are ignored (req_ready=0).
- size = 1/2/4 for funct3[1:0] = 00/01/10; off = addr[1:0]; cross = (off+size > 4).
- Illegal funct3 (011, 11x, 110/111, and any store with funct3[2]=1): LO is still entered with mem_we=0 and mem_wmask=0, then DONE with resp_err=1.
- Crossing access with SUPPORT_MISALIGNED=0: handled the same way as an illegal funct3.
- LO: mem_a = {addr[31:2],2'b00}.
  - mem_wd = wdata << 8*off, truncated to 32 bits.
  - mem_wmask = smask << 8*off, truncated, where smask = 0xFF / 0xFFFF / 0xFFFFFFFF.
  - mem_we = we.
  - Capture mem_rd into lo_word.
  - Next state: HI if cross (and legal), else DONE.
- HI: mem_a = lo address + 4, mod 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - mem_wd = wdata >> 8*(4-off).
  - mem_wmask = smask >> 8*(4-off).
  - Capture mem_rd into hi_word. Next state DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. req_ready stays 0 in DONE, so back-to-back issue is at best every 3 cycles.
- Load data: ({hi_word,lo_word} >> 8*off)[31:0], then sign-extended (b, h) or zero-extended (bu, hu); w is passed through. hi_word is 0 for non-crossing accesses.
- In IDLE and DONE: mem_we, mem_a, mem_wd and mem_wmask are all 0.
- mem_we is gated with !reset, so no dmem write occurs at any edge where reset is high.
- Latency (request accepted at edge N): non-crossing resp_valid in cycle N+2; crossing resp_valid in N+3.
- Reset mid-operation: abort immediately and return to IDLE. No resp_valid is issued for the aborted request. If reset hits during HI, the LO write has already committed; the HI write is suppressed.

Test Plan:
- sw addr 0x100, wdata 0x11223344 -> LO: mem_a 0x100, mem_wd 0x11223344, mem_wmask 0xFFFFFFFF, mem_we 1; resp_valid in N+2, resp_err 0.
- sb addr 0x101, wdata 0x000000A5 -> mem_wd 0x0000A500, mem_wmask 0x0000FF00; sh addr 0x102, wdata 0xBEEF -> mem_wmask 0xFFFF0000, mem_wd 0xBEEF0000.
- dmem[0x200]=0x80112233: lb 0x203 -> 0xFFFFFF80; lbu 0x203 -> 0x00000080; lh 0x202 -> 0xFFFF8011; lhu 0x202 -> 0x00008011.
- Crossing: dmem[0x204]=0x44556677. lh 0x203 -> LO mem_a 0x200, HI mem_a 0x204, resp 0x00007780 at N+3. sw 0x102, wdata 0xAABBCCDD -> LO mem_wd 0xCCDD0000 / mem_wmask 0xFFFF0000; HI mem_wd 0x0000AABB / mem_wmask 0x0000FFFF.
- Wrap and error: lw 0xFFFFFFFE -> HI mem_a 0x00000000. funct3 011 -> mem_we 0 throughout, resp_err 1 at N+2. SUPPORT_MISALIGNED=0 with lw 0x101 -> resp_err 1, no write.
- Reset asserted during HI of a crossing store -> HI write absent, no resp_valid, req_ready=1 in the first cycle after reset deasserts; next request completes normally.

Source files
------------

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter between the execute stage and a word-addressed dmem.
// One request at a time. Word-crossing accesses become a LO access followed
// by a HI access to the next word. Load data is aligned and extended here.
module lsu_mem_adapter #(
    parameter bit SUPPORT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_wmask,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic [31:0] r_lo_word;
    logic        r_err;
    logic        r_cross;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic        r_mem_we;
    logic [31:0] r_mem_a;
    logic [31:0] r_mem_wd;
    logic [31:0] r_mem_wmask;

    logic [1:0]  w_off;
    logic        w_cross_in;
    logic        w_err_in;
    logic [31:0] w_lo_wd;
    logic [31:0] w_lo_wm;
    logic [5:0]  w_hi_sh;
    logic [31:0] w_hi_wd;
    logic [31:0] w_hi_wm;
    logic [31:0] w_lo_word;
    logic [31:0] w_hi_word;
    logic [31:0] w_raw;
    logic [31:0] w_resp_rdata;

    // Access size in bytes for funct3[1:0]; the 11 encoding is illegal anyway.
    function automatic logic [2:0] f_size(input logic [1:0] sz);
        case (sz)
            2'b00:   f_size = 3'd1;
            2'b01:   f_size = 3'd2;
            default: f_size = 3'd4;
        endcase
    endfunction

    // Byte-lane mask of an access starting at lane 0, 0xFF per byte.
    function automatic logic [31:0] f_smask(input logic [1:0] sz);
        case (sz)
            2'b00:   f_smask = 32'h0000_00FF;
            2'b01:   f_smask = 32'h0000_FFFF;
            default: f_smask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Loads accept b/h/w/bu/hu; stores only b/h/w.
    function automatic logic f_legal(input logic we, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: f_legal = 1'b1;
            3'b100, 3'b101:         f_legal = ~we;
            default:                f_legal = 1'b0;
        endcase
    endfunction

    // True when the access spills into the next word.
    function automatic logic f_cross(input logic [1:0] off, input logic [1:0] sz);
        f_cross = (({1'b0, off} + f_size(sz)) > 3'd4);
    endfunction

    // Sign- or zero-extension of right-justified load data.
    function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  f_extend = {{24{raw[7]}}, raw[7:0]};
            3'b001:  f_extend = {{16{raw[15]}}, raw[15:0]};
            3'b100:  f_extend = {24'h00_0000, raw[7:0]};
            3'b101:  f_extend = {16'h0000, raw[15:0]};
            default: f_extend = raw;
        endcase
    endfunction

    // Request decode, lane shifting for both halves, and load-data assembly.
    always_comb begin
        w_off      = req_addr[1:0];
        w_cross_in = f_cross(w_off, req_funct3[1:0]);
        if (!f_legal(req_we, req_funct3)) begin
            w_err_in = 1'b1;
        end else if (w_cross_in && (SUPPORT_MISALIGNED == 1'b0)) begin
            w_err_in = 1'b1;
        end else begin
            w_err_in = 1'b0;
        end
        w_lo_wd = req_wdata << {w_off, 3'b000};
        w_lo_wm = f_smask(req_funct3[1:0]) << {w_off, 3'b000};
        // Shifting by 32 (offset 0) yields zero, which is the intended HI share.
        w_hi_sh = 6'd32 - {1'b0, r_off, 3'b000};
        w_hi_wd = r_wdata >> w_hi_sh;
        w_hi_wm = f_smask(r_funct3[1:0]) >> w_hi_sh;
        if (r_state == ST_HI) begin
            w_hi_word = mem_rd;
            w_lo_word = r_lo_word;
        end else begin
            w_hi_word = 32'h0000_0000;
            w_lo_word = mem_rd;
        end
        w_raw = (w_lo_word >> {r_off, 3'b000}) | (w_hi_word << w_hi_sh);
        if (r_we || r_err) begin
            w_resp_rdata = 32'h0000_0000;
        end else begin
            w_resp_rdata = f_extend(r_funct3, w_raw);
        end
    end

    // Main FSM: captures the request, drives registered dmem controls, issues the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_off        <= 2'b00;
            r_wdata      <= 32'h0000_0000;
            r_lo_word    <= 32'h0000_0000;
            r_err        <= 1'b0;
            r_cross      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_mem_we     <= 1'b0;
            r_mem_a      <= 32'h0000_0000;
            r_mem_wd     <= 32'h0000_0000;
            r_mem_wmask  <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_funct3    <= req_funct3;
                        r_off       <= w_off;
                        r_wdata     <= req_wdata;
                        r_err       <= w_err_in;
                        r_cross     <= w_cross_in & ~w_err_in;
                        r_req_ready <= 1'b0;
                        r_mem_a     <= {req_addr[31:2], 2'b00};
                        r_mem_we    <= req_we & ~w_err_in;
                        r_mem_wd    <= w_err_in ? 32'h0000_0000 : w_lo_wd;
                        r_mem_wmask <= w_err_in ? 32'h0000_0000 : w_lo_wm;
                        r_state     <= ST_LO;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_LO: begin
                    r_lo_word <= mem_rd;
                    if (r_cross) begin
                        // Address wraps mod 2^32 by construction of the 32-bit add.
                        r_mem_a     <= r_mem_a + 32'd4;
                        r_mem_wd    <= w_hi_wd;
                        r_mem_wmask <= w_hi_wm;
                        r_state     <= ST_HI;
                    end else begin
                        r_mem_we     <= 1'b0;
                        r_mem_a      <= 32'h0000_0000;
                        r_mem_wd     <= 32'h0000_0000;
                        r_mem_wmask  <= 32'h0000_0000;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= r_err;
                        r_resp_rdata <= w_resp_rdata;
                        r_state      <= ST_DONE;
                    end
                end
                ST_HI: begin
                    r_mem_we     <= 1'b0;
                    r_mem_a      <= 32'h0000_0000;
                    r_mem_wd     <= 32'h0000_0000;
                    r_mem_wmask  <= 32'h0000_0000;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= r_err;
                    r_resp_rdata <= w_resp_rdata;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    // Write enable is masked by reset so an aborted HI phase never writes.
    assign mem_we     = r_mem_we & ~reset;
    assign mem_a      = r_mem_a;
    assign mem_wd     = r_mem_wd;
    assign mem_wmask  = r_mem_wmask;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Bench for lsu_mem_adapter: directed vector table, hand-written reset/abort
// and no-misalign sequences, then random traffic against a byte-level model.
module tb_lsu_mem_adapter;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_wmask, mem_rd;

    logic        n_req_valid, n_req_ready, n_req_we;
    logic [2:0]  n_req_funct3;
    logic [31:0] n_req_addr, n_req_wdata;
    logic        n_resp_valid, n_resp_err;
    logic [31:0] n_resp_rdata;
    logic        n_mem_we;
    logic [31:0] n_mem_a, n_mem_wd, n_mem_wmask, n_mem_rd;

    int checks = 0;
    int errors = 0;

    lsu_mem_adapter #(.SUPPORT_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_wmask(mem_wmask),
        .mem_rd(mem_rd)
    );

    lsu_mem_adapter #(.SUPPORT_MISALIGNED(1'b0)) u_dut_nomis (
        .clk(clk), .reset(reset),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
        .req_funct3(n_req_funct3), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
        .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_err(n_resp_err),
        .mem_we(n_mem_we), .mem_a(n_mem_a), .mem_wd(n_mem_wd), .mem_wmask(n_mem_wmask),
        .mem_rd(n_mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench dmem: 256 words, indexed by address bits [9:2], combinational read.
    logic [31:0] dmem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (pl_en) begin
            dmem[pl_idx] <= pl_data;
        end else if (mem_we) begin
            dmem[mem_a[9:2]] <= (dmem[mem_a[9:2]] & ~mem_wmask) | (mem_wd & mem_wmask);
            wr_cnt <= wr_cnt + 1;
        end
    end
    assign mem_rd   = dmem[mem_a[9:2]];
    assign n_mem_rd = 32'h1234_5678;

    // Byte-level reference memory for the random phase (address mod 1024).
    logic [7:0] ref_mem [0:1023];

    logic        tr_we [0:7];
    logic [31:0] tr_a  [0:7];
    logic [31:0] tr_wd [0:7];
    logic [31:0] tr_wm [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = 8'(idx);
        pl_data = data;
        @(posedge clk);
        #1;
        pl_en   = 1'b0;
    endtask

    // Issue one request; trace bus per cycle; lat = cycles after accept edge until resp_valid.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output int lat,
                           output logic [31:0] rd, output logic er);
        lat = -1;
        rd  = 32'h0;
        er  = 1'b0;
        @(negedge clk);
        chk("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tr_we[k] = mem_we;
            tr_a[k]  = mem_a;
            tr_wd[k] = mem_wd;
            tr_wm[k] = mem_wmask;
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat < 0) begin
            chk("resp_timeout", 32'h0, 32'h1);
        end else begin
            chk("done_bus_idle", {31'h0, mem_we} | mem_a | mem_wd | mem_wmask, 32'h0);
            @(posedge clk);
            #1;
            chk("resp_one_pulse", {30'h0, resp_valid, req_ready}, 32'h1);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        lo_we;
        logic [31:0] lo_a;
        logic [31:0] lo_wd;
        logic [31:0] lo_wm;
        logic [31:0] hi_a;
        logic [31:0] hi_wd;
        logic [31:0] hi_wm;
    } vec_t;

    vec_t vecs [0:13];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          wc0;

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        n_req_valid = 1'b0; n_req_we = 1'b0; n_req_funct3 = 3'b000; n_req_addr = 32'h0; n_req_wdata = 32'h0;
        pl_en = 1'b0; pl_idx = 8'h00; pl_data = 32'h0;

        vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'h1122_3344, 1, 1'b0, 32'h0,
                     1'b1, 32'h0000_0100, 32'h1122_3344, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 1, 1'b0, 32'h0,
                     1'b1, 32'h0000_0100, 32'h0000_A500, 32'h0000_FF00, 32'h0, 32'h0, 32'h0};
        vecs[2]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 1, 1'b0, 32'h0,
                     1'b1, 32'h0000_0100, 32'hBEEF_0000, 32'hFFFF_0000, 32'h0, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 3'b000, 32'h0000_0203, 32'h0, 1, 1'b0, 32'hFFFF_FF80,
                     1'b0, 32'h0000_0200, 32'h0, 32'hFF00_0000, 32'h0, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 3'b100, 32'h0000_0203, 32'h0, 1, 1'b0, 32'h0000_0080,
                     1'b0, 32'h0000_0200, 32'h0, 32'hFF00_0000, 32'h0, 32'h0, 32'h0};
        vecs[5]  = '{1'b0, 3'b001, 32'h0000_0202, 32'h0, 1, 1'b0, 32'hFFFF_8011,
                     1'b0, 32'h0000_0200, 32'h0, 32'hFFFF_0000, 32'h0, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 3'b101, 32'h0000_0202, 32'h0, 1, 1'b0, 32'h0000_8011,
                     1'b0, 32'h0000_0200, 32'h0, 32'hFFFF_0000, 32'h0, 32'h0, 32'h0};
        vecs[7]  = '{1'b0, 3'b001, 32'h0000_0203, 32'h0, 2, 1'b0, 32'h0000_7780,
                     1'b0, 32'h0000_0200, 32'h0, 32'hFF00_0000, 32'h0000_0204, 32'h0, 32'h0000_00FF};
        vecs[8]  = '{1'b1, 3'b010, 32'h0000_0102, 32'hAABB_CCDD, 2, 1'b0, 32'h0,
                     1'b1, 32'h0000_0100, 32'hCCDD_0000, 32'hFFFF_0000, 32'h0000_0104, 32'h0000_AABB, 32'h0000_FFFF};
        vecs[9]  = '{1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 2, 1'b0, 32'hBEEF_DEAD,
                     1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_0000, 32'h0000_0000, 32'h0, 32'h0000_FFFF};
        vecs[10] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0, 1, 1'b1, 32'h0,
                     1'b0, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 3'b100, 32'h0000_0101, 32'h0, 1, 1'b1, 32'h0,
                     1'b0, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[12] = '{1'b0, 3'b101, 32'h0000_0201, 32'h0, 1, 1'b0, 32'h0000_1122,
                     1'b0, 32'h0000_0200, 32'h0, 32'h00FF_FF00, 32'h0, 32'h0, 32'h0};
        vecs[13] = '{1'b0, 3'b010, 32'h0000_0200, 32'h0, 1, 1'b0, 32'h8011_2233,
                     1'b0, 32'h0000_0200, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};

        // Preload memory while the DUTs are held in reset.
        for (int w = 0; w < 256; w++) begin
            case (w)
                8'h80:   preload(w, 32'h8011_2233);
                8'h81:   preload(w, 32'h4455_6677);
                8'hFF:   preload(w, 32'hDEAD_0000);
                8'h00:   preload(w, 32'h0000_BEEF);
                default: preload(w, 32'h0000_0000);
            endcase
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata,          32'h0);
        chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
        chk("rst_mem_bus",    {31'h0, mem_we} | mem_a | mem_wd | mem_wmask, 32'h0);

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            wc0 = wr_cnt;
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rd, er);
            chk($sformatf("v%0d_lat", i),   32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_err", i),   {31'h0, er}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_lo_we", i), {31'h0, tr_we[0]}, {31'h0, vecs[i].lo_we});
            chk($sformatf("v%0d_lo_a", i),  tr_a[0],  vecs[i].lo_a);
            chk($sformatf("v%0d_lo_wd", i), tr_wd[0], vecs[i].lo_wd);
            chk($sformatf("v%0d_lo_wm", i), tr_wm[0], vecs[i].lo_wm);
            if (vecs[i].exp_lat == 2) begin
                chk($sformatf("v%0d_hi_we", i), {31'h0, tr_we[1]}, {31'h0, vecs[i].lo_we});
                chk($sformatf("v%0d_hi_a", i),  tr_a[1],  vecs[i].hi_a);
                chk($sformatf("v%0d_hi_wd", i), tr_wd[1], vecs[i].hi_wd);
                chk($sformatf("v%0d_hi_wm", i), tr_wm[1], vecs[i].hi_wm);
            end
            chk($sformatf("v%0d_writes", i), 32'(wr_cnt - wc0),
                (vecs[i].we && !vecs[i].exp_err) ? 32'(vecs[i].exp_lat) : 32'h0);
        end
        chk("mem_after_sw_cross_lo", dmem[8'h40], 32'hCCDD_A544);
        chk("mem_after_sw_cross_hi", dmem[8'h41], 32'h0000_AABB);

        // No-misalign instance: crossing lw errors without writing; aligned lw works.
        @(negedge clk);
        n_req_valid = 1'b1; n_req_we = 1'b0; n_req_funct3 = 3'b010; n_req_addr = 32'h0000_0101;
        @(posedge clk); #1;
        n_req_valid = 1'b0;
        chk("nomis_lo_we", {31'h0, n_mem_we}, 32'h0);
        chk("nomis_lo_wm", n_mem_wmask, 32'h0);
        @(posedge clk); #1;
        chk("nomis_resp", {29'h0, n_resp_valid, n_resp_err, n_mem_we}, 32'h6);
        chk("nomis_rdata", n_resp_rdata, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        n_req_valid = 1'b1; n_req_addr = 32'h0000_0100;
        @(posedge clk); #1;
        n_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("nomis_aligned_resp", {30'h0, n_resp_valid, n_resp_err}, 32'h2);
        chk("nomis_aligned_rdata", n_resp_rdata, 32'h1234_5678);

        // Reset during HI of a crossing store: LO write kept, HI write dropped.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0000_00F2; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_hi_lo_we", {31'h0, mem_we}, 32'h1);
        @(posedge clk); #1;
        chk("rst_hi_hi_a", mem_a, 32'h0000_00F4);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_hi_we_gated", {31'h0, mem_we}, 32'h0);
        @(posedge clk); #1;
        chk("rst_hi_no_resp", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_hi_ready_after", {31'h0, req_ready}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_hi_no_resp_later", {31'h0, resp_valid}, 32'h0);
        end
        chk("rst_hi_lo_word", dmem[8'h3C], 32'hF00D_0000);
        chk("rst_hi_hi_word", dmem[8'h3D], 32'h0000_0000);
        run_txn(1'b0, 3'b010, 32'h0000_00F2, 32'h0, lat, rd, er);
        chk("rst_hi_next_lat", 32'(lat), 32'd2);
        chk("rst_hi_next_rdata", rd, 32'h0000_F00D);

        // Random traffic against a byte-level model.
        for (int w = 0; w < 256; w++) begin
            logic [31:0] v;
            v = $urandom();
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = v[8*b +: 8];
            preload(w, v);
        end
        for (int t = 0; t < 250; t++) begin
            logic        rwe;
            logic [2:0]  rf3;
            logic [31:0] ra, rwd, ev;
            int          sz, off, elat;
            logic        legal;
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom();
            rwd = $urandom();
            sz  = (rf3[1:0] == 2'b00) ? 1 : ((rf3[1:0] == 2'b01) ? 2 : 4);
            legal = (rf3 == 3'b000) || (rf3 == 3'b001) || (rf3 == 3'b010) ||
                    (!rwe && ((rf3 == 3'b100) || (rf3 == 3'b101)));
            off  = int'(ra % 4);
            elat = (legal && (off + sz > 4)) ? 2 : 1;
            ev   = 32'h0;
            if (legal && !rwe) begin
                for (int b = 0; b < sz; b++) ev = ev + (32'(ref_mem[(ra + 32'(b)) % 1024]) << (8*b));
                if (rf3 == 3'b000 && ev >= 32'd128)   ev = ev + 32'hFFFF_FF00;
                if (rf3 == 3'b001 && ev >= 32'd32768) ev = ev + 32'hFFFF_0000;
            end
            if (legal && rwe) begin
                for (int b = 0; b < sz; b++) ref_mem[(ra + 32'(b)) % 1024] = 8'(rwd >> (8*b));
            end
            run_txn(rwe, rf3, ra, rwd, lat, rd, er);
            chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_err", t), {31'h0, er}, {31'h0, !legal});
            chk($sformatf("rnd%0d_rdata", t), rd, ev);
        end
        for (int w = 0; w < 256; w++) begin
            chk($sformatf("rnd_mem_word%0d", w), dmem[w],
                {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
